// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request, scoreboard query and register-file write bundle.
interface regfile_wb_arbiter_if #(parameter int NREQ = 3);
    logic [NREQ-1:0]    Req;
    logic [5*NREQ-1:0]  ReqAddr;
    logic [32*NREQ-1:0] ReqData;
    logic [NREQ-1:0]    Ack;
    logic               ResvValid;
    logic [4:0]         ResvAddr;
    logic               Flush;
    logic [4:0]         RsAddr;
    logic [4:0]         RtAddr;
    logic               RsBusy;
    logic               RtBusy;
    logic               RsBypass;
    logic               RtBypass;
    logic [31:0]        BypData;
    logic               RegWrite;
    logic [4:0]         RdAddr;
    logic [31:0]        RdData;
    modport master (
        output Req, ReqAddr, ReqData, ResvValid, ResvAddr, Flush, RsAddr, RtAddr,
        input  Ack, RsBusy, RtBusy, RsBypass, RtBypass, BypData, RegWrite, RdAddr, RdData
    );
    modport slave (
        input  Req, ReqAddr, ReqData, ResvValid, ResvAddr, Flush, RsAddr, RtAddr,
        output Ack, RsBusy, RtBusy, RsBypass, RtBypass, BypData, RegWrite, RdAddr, RdData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with pending-write scoreboard.
// Define WB_BYPASS_EN to expose the registered write as a same-cycle bypass.
module regfile_wb_arbiter #(
    parameter int NREQ = 3
) (
    input logic                 Clock,
    input logic                 Reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [PW-1:0]   last;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] ack;
    logic [4:0]      gaddr;
    logic [31:0]     gdata;
    logic [31:0]     sb;
    logic [31:0]     sb_next;
    logic [31:0]     clr;
    logic [31:0]     set;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [31:0]     rd_data;
    logic            rs_byp;
    logic            rt_byp;
    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        ack   = '0;
        found = 1'b0;
        gidx  = last;
        cand  = '0;
        gaddr = '0;
        gdata = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(last) + k) % NREQ);
            if (!found && bus.Req[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (found && gidx == PW'(k)) begin
                ack[k] = 1'b1;
                gaddr  = bus.ReqAddr[5*k +: 5];
                gdata  = bus.ReqData[32*k +: 32];
            end
        end
    end
    // A same-edge reservation re-arms the bit, even across a clear or flush.
    always_comb begin
        clr     = found ? (32'd1 << gaddr) : '0;
        set     = bus.ResvValid ? (32'd1 << bus.ResvAddr) : '0;
        sb_next = ((bus.Flush ? '0 : (sb & ~clr)) | set) & ~32'd1;
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            reg_write <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            last      <= PW'(NREQ - 1);
            sb        <= '0;
        end else begin
            reg_write <= found && gaddr != 5'd0;
            sb        <= sb_next;
            if (found) begin
                rd_addr <= gaddr;
                rd_data <= gdata;
                last    <= gidx;
            end
        end
    end
`ifdef WB_BYPASS_EN
    always_comb begin
        rs_byp = reg_write && rd_addr == bus.RsAddr && bus.RsAddr != 5'd0;
        rt_byp = reg_write && rd_addr == bus.RtAddr && bus.RtAddr != 5'd0;
    end
    assign bus.BypData = rd_data;
`else
    always_comb begin
        rs_byp = 1'b0;
        rt_byp = 1'b0;
    end
    assign bus.BypData = '0;
`endif
    assign bus.Ack      = ack;
    assign bus.RsBusy   = sb[bus.RsAddr] && !rs_byp;
    assign bus.RtBusy   = sb[bus.RtAddr] && !rt_byp;
    assign bus.RsBypass = rs_byp;
    assign bus.RtBypass = rt_byp;
    assign bus.RegWrite = reg_write;
    assign bus.RdAddr   = rd_addr;
    assign bus.RdData   = rd_data;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single synchronous write port between several writeback requesters: ALU, multiply/divide unit and load/store unit.
Keeps a pending-write scoreboard, one bit per architectural register, so issue logic can stall on RAW hazards.
Sits between the execution units and the 32-entry register file. It drives the register file's RegWrite/RdAddr/RdData inputs from registers.

Parameters:
NREQ, 3, number of writeback requesters (2..8); index 0 = ALU, 1 = MDU, 2 = LSU.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Req  input  NREQ  per-requester writeback request
ReqAddr  input  5*NREQ  destination register per requester; slice i = [5i+4:5i]
ReqData  input  32*NREQ  writeback data per requester; slice i = [32i+31:32i]
Ack  output  NREQ  one-hot grant, combinational
ResvValid  input  1  issue stage reserves a destination register
ResvAddr  input  5  register being reserved
Flush  input  1  clear all scoreboard bits
RsAddr  input  5  hazard query address A
RtAddr  input  5  hazard query address B
RsBusy  output  1  pending write outstanding for RsAddr
RtBusy  output  1  pending write outstanding for RtAddr
RsBypass  output  1  RsAddr is being written this cycle (feature only)
RtBypass  output  1  RtAddr is being written this cycle (feature only)
BypData  output  32  equals RdData (feature only)
RegWrite  output  1  register file write enable, registered
RdAddr  output  5  register file write address, registered
RdData  output  32  register file write data, registered

Behaviour:
- Reset (asynchronous, any time): RegWrite=0, RdAddr=0, RdData=0, all scoreboard bits=0, last-grant pointer=NREQ-1 so requester 0 has first priority.
- Reset mid-operation discards any granted-but-unwritten data.
- Handshake: requester asserts Req with Addr/Data stable and holds until it sees Ack. Ack is combinational in the same cycle. Requester may drop or change the request the following cycle.
- Arbitration: round-robin. Search starts at (last+1) mod NREQ and grants the first asserted Req. At most one Ack per cycle.
- Pointer updates to the granted index only on a cycle with a grant. No grant → pointer unchanged, Ack=0.
- Latency: a grant in cycle N produces RegWrite=1 with RdAddr/RdData in cycle N+1. The register file commits at edge N+2.
- No grant in cycle N → RegWrite=0 in N+1; RdAddr/RdData hold their previous values.
- Throughput: one write per cycle; grants are back-to-back with no bubble.
- Address 0: the request is granted and acked normally, but RegWrite is forced to 0 for that write.
- Scoreboard bit k:
  - Set at the edge when ResvValid=1 and ResvAddr=k (k≠0).
  - Cleared at the edge when a grant to address k occurs.
- Priority at a single edge, highest first:
  - Reserve wins over same-edge clear of the same address (a new producer is issued).
  - Flush clears all bits; a same-edge ResvValid is applied after the flush, so that bit ends set.
- Bit 0 is always 0.
- RsBusy/RtBusy are combinational from the scoreboard bits. Query address 0 → 0.
- Out-of-order completion to the same register is the issue stage's problem; the scoreboard holds one bit per register, not a counter.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - RsBypass=1 when RegWrite=1 and RdAddr==RsAddr≠0; RsBusy is then forced to 0.
  - RtBypass/RtBusy follow the same rule for RtAddr.
  - BypData=RdData.
- Undefined: RsBypass=RtBypass=0, BypData=0, and Busy reflects the scoreboard only. Ports still exist.

Test Plan:
- Reset → RegWrite=0, RdAddr=0, RdData=0, Ack=0, RsBusy=RtBusy=0 for every query address 0..31.
- Single request: Req=001, ReqAddr[4:0]=5, ReqData[31:0]=0xDEADBEEF in cycle N → Ack=001 in N; in N+1 RegWrite=1, RdAddr=5, RdData=0xDEADBEEF; in N+2 RegWrite=0.
- All three Req held constantly, with each requester dropping its Req for one cycle after its Ack → grants cycle 0,1,2,0 across four consecutive cycles, one Ack per cycle, no idle cycle.
- Write to register 0: Req=010 with ReqAddr=0 → Ack=010, next cycle RegWrite=0.
- Scoreboard:
  - ResvValid with ResvAddr=7 → next cycle RsAddr=7 gives RsBusy=1.
  - Grant to address 7 → after that edge RsBusy=0.
  - ResvValid=7 coinciding with a grant to 7 → bit stays 1.
  - Flush with ResvValid=9 → only bit 9 set.
- WB_BYPASS_EN defined, reg 3 reserved, RegWrite=1 with RdAddr=3, RdData=0x12, RsAddr=3 → RsBusy=0, RsBypass=1, BypData=0x12. Same stimulus without the macro → RsBusy=1, RsBypass=0.
